// File: rtl/wb_ddr_arbiter_pkg.sv
// Shared definitions for the LM32-to-DDR Wishbone arbiter: bus widths,
// arbiter state encodings and the state-to-grant mapping.
package wb_ddr_arbiter_pkg;

    localparam int SEL_W  = 4;
    localparam int DATA_W = 32;
    localparam int ADR_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS0 = 2'd1,
        ST_BUS1 = 2'd2
    } arb_state_e;

    // One-hot owner for a given arbiter state; idle and unused codes own nothing.
    function automatic logic [1:0] state_grant(input arb_state_e st);
        logic [1:0] g;
        case (st)
            ST_BUS0: g = 2'b01;
            ST_BUS1: g = 2'b10;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Bus watchdog: counts unacknowledged strobe cycles, flags expiry and keeps a
// saturating tally of expiry events.
module wb_watchdog #(
    parameter int timeout    = 1024,
    parameter int tcnt_width = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  active,
    input  logic                  stb,
    input  logic                  ack,
    output logic                  expire,
    output logic [tcnt_width-1:0] timeout_cnt
);

    localparam int CW = $clog2(timeout);
    localparam logic [CW-1:0] LIMIT = CW'(timeout - 1);

    logic [CW-1:0]         cnt_r;
    logic [tcnt_width-1:0] tcnt_r;
    logic                  waiting_s;

    // An ack in the final cycle beats the watchdog.
    assign waiting_s   = active & stb & ~ack;
    assign expire      = waiting_s & (cnt_r == LIMIT);
    assign timeout_cnt = tcnt_r;

    // Wait counter: advances while a strobe is unanswered, clears otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (waiting_s && !expire) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= '0;
        end
    end

    // Expiry event tally, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt_r <= '0;
        end else if (expire && (tcnt_r != '1)) begin
            tcnt_r <= tcnt_r + tcnt_width'(1);
        end else begin
            tcnt_r <= tcnt_r;
        end
    end

endmodule

// File: rtl/wb_ddr_arbiter.sv
// Two-master round-robin Wishbone arbiter with cyc-based bus lock, sharing the
// DDR controller port between the LM32 instruction and data buses.
module wb_ddr_arbiter
    import wb_ddr_arbiter_pkg::*;
#(
    parameter int timeout    = 1024,
    parameter int tcnt_width = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m0_cyc,
    input  logic                  m0_stb,
    input  logic                  m0_we,
    input  logic [SEL_W-1:0]      m0_sel,
    input  logic [ADR_W-1:0]      m0_adr,
    input  logic [DATA_W-1:0]     m0_dat_w,
    output logic [DATA_W-1:0]     m0_dat_r,
    output logic                  m0_ack,
    output logic                  m0_err,
    input  logic                  m1_cyc,
    input  logic                  m1_stb,
    input  logic                  m1_we,
    input  logic [SEL_W-1:0]      m1_sel,
    input  logic [ADR_W-1:0]      m1_adr,
    input  logic [DATA_W-1:0]     m1_dat_w,
    output logic [DATA_W-1:0]     m1_dat_r,
    output logic                  m1_ack,
    output logic                  m1_err,
    output logic                  s_cyc,
    output logic                  s_stb,
    output logic                  s_we,
    output logic [SEL_W-1:0]      s_sel,
    output logic [ADR_W-1:0]      s_adr,
    output logic [DATA_W-1:0]     s_dat_w,
    input  logic [DATA_W-1:0]     s_dat_r,
    input  logic                  s_ack,
    output logic [1:0]            grant,
    output logic [tcnt_width-1:0] timeout_cnt
);

    arb_state_e state_r;
    logic       last_r;
    logic       expire_s;
    logic       wd_active_s;
    logic       wd_stb_s;

    assign grant    = state_grant(state_r);
    assign m0_dat_r = s_dat_r;
    assign m1_dat_r = s_dat_r;

    // Watchdog inputs depend only on state and master strobes, never on the muxed outputs.
    assign wd_active_s = (state_r == ST_BUS0) || (state_r == ST_BUS1);
    assign wd_stb_s    = ((state_r == ST_BUS0) && m0_stb) || ((state_r == ST_BUS1) && m1_stb);

    wb_watchdog #(
        .timeout    (timeout),
        .tcnt_width (tcnt_width)
    ) u_watchdog (
        .clk         (clk),
        .reset       (reset),
        .active      (wd_active_s),
        .stb         (wd_stb_s),
        .ack         (s_ack),
        .expire      (expire_s),
        .timeout_cnt (timeout_cnt)
    );

    // Arbitration FSM; last_r names the most recent owner so the other wins a tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            last_r  <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (m0_cyc && m1_cyc) begin
                        state_r <= last_r ? ST_BUS0 : ST_BUS1;
                    end else if (m0_cyc) begin
                        state_r <= ST_BUS0;
                    end else if (m1_cyc) begin
                        state_r <= ST_BUS1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUS0: begin
                    if (expire_s || !m0_cyc) begin
                        state_r <= ST_IDLE;
                        last_r  <= 1'b0;
                    end else begin
                        state_r <= ST_BUS0;
                    end
                end
                ST_BUS1: begin
                    if (expire_s || !m1_cyc) begin
                        state_r <= ST_IDLE;
                        last_r  <= 1'b1;
                    end else begin
                        state_r <= ST_BUS1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Slave-side mux and master responses; only the owner sees ack or err.
    always_comb begin
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_sel   = '0;
        s_adr   = '0;
        s_dat_w = '0;
        m0_ack  = 1'b0;
        m0_err  = 1'b0;
        m1_ack  = 1'b0;
        m1_err  = 1'b0;
        case (state_r)
            ST_BUS0: begin
                s_cyc   = m0_cyc;
                s_stb   = m0_stb & ~expire_s;
                s_we    = m0_we;
                s_sel   = m0_sel;
                s_adr   = m0_adr;
                s_dat_w = m0_dat_w;
                m0_ack  = s_ack & m0_stb;
                m0_err  = expire_s;
            end
            ST_BUS1: begin
                s_cyc   = m1_cyc;
                s_stb   = m1_stb & ~expire_s;
                s_we    = m1_we;
                s_sel   = m1_sel;
                s_adr   = m1_adr;
                s_dat_w = m1_dat_w;
                m1_ack  = s_ack & m1_stb;
                m1_err  = expire_s;
            end
            default: begin
                s_cyc = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_ddr_arbiter.sv
// Directed bench for wb_ddr_arbiter with a 16-cycle watchdog and a 2-bit
// event counter; the bench plays the slave itself.
module tb_wb_ddr_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_cyc, m0_stb, m0_we, m0_ack, m0_err;
    logic [3:0]  m0_sel;
    logic [31:0] m0_adr, m0_dat_w, m0_dat_r;
    logic        m1_cyc, m1_stb, m1_we, m1_ack, m1_err;
    logic [3:0]  m1_sel;
    logic [31:0] m1_adr, m1_dat_w, m1_dat_r;
    logic        s_cyc, s_stb, s_we, s_ack;
    logic [3:0]  s_sel;
    logic [31:0] s_adr, s_dat_w, s_dat_r;
    logic [1:0]  grant;
    logic [1:0]  timeout_cnt;

    int checks = 0;
    int errors = 0;

    wb_ddr_arbiter #(
        .timeout    (16),
        .tcnt_width (2)
    ) dut (
        .clk(clk), .reset(reset),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel),
        .m0_adr(m0_adr), .m0_dat_w(m0_dat_w), .m0_dat_r(m0_dat_r),
        .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel),
        .m1_adr(m1_adr), .m1_dat_w(m1_dat_w), .m1_dat_r(m1_dat_r),
        .m1_ack(m1_ack), .m1_err(m1_err),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel),
        .s_adr(s_adr), .s_dat_w(s_dat_w), .s_dat_r(s_dat_r), .s_ack(s_ack),
        .grant(grant), .timeout_cnt(timeout_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge (drive point).
    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    // Sample point, half a cycle away from the active edge.
    task automatic smp();
        @(negedge clk);
    endtask

    task automatic drop_all();
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
        s_ack  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drop_all();
        nx();
        nx();
        reset = 1'b0;
    endtask

    task automatic wait_err(output logic seen);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            nx();
            smp();
            if (m1_err) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    logic seen;
    logic [1:0] exp_tc;

    initial begin
        reset = 1'b1;
        drop_all();
        m0_sel = 4'hF; m0_adr = 32'h0; m0_dat_w = 32'h0;
        m1_sel = 4'hF; m1_adr = 32'h0; m1_dat_w = 32'h0;
        s_dat_r = 32'h0;

        // Reset state
        nx(); nx(); smp();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_s_cyc", 32'(s_cyc), 32'd0);
        chk("rst_s_stb", 32'(s_stb), 32'd0);
        chk("rst_acks", 32'({m0_ack, m1_ack, m0_err, m1_err}), 32'd0);
        chk("rst_tcnt", 32'(timeout_cnt), 32'd0);
        nx();
        reset = 1'b0;

        // Single master read from m1
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h4000_0010;
        smp();
        chk("t1_idle_grant", 32'(grant), 32'd0);
        chk("t1_no_fwd", 32'(s_stb), 32'd0);
        nx(); smp();
        chk("t1_grant", 32'(grant), 32'd2);
        chk("t1_s_adr", s_adr, 32'h4000_0010);
        chk("t1_s_stb", 32'(s_stb), 32'd1);
        chk("t1_wait_ack", 32'(m1_ack), 32'd0);
        for (int i = 0; i < 2; i++) begin
            nx(); smp();
            chk("t1_wait_ack", 32'(m1_ack), 32'd0);
        end
        nx();
        s_ack = 1'b1; s_dat_r = 32'hDEAD_BEEF;
        smp();
        chk("t1_m1_ack", 32'(m1_ack), 32'd1);
        chk("t1_m1_dat", m1_dat_r, 32'hDEAD_BEEF);
        chk("t1_m0_ack", 32'(m0_ack), 32'd0);
        nx();
        drop_all();
        smp();
        chk("t1_ack_gone", 32'(m1_ack), 32'd0);
        nx(); smp();
        chk("t1_idle", 32'(grant), 32'd0);

        // Simultaneous requests alternate starting with m0
        do_reset();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h0000_1000;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h0000_2000;
        for (int r = 0; r < 4; r++) begin
            nx();
            s_ack = 1'b1;
            smp();
            chk("rr_grant", 32'(grant), (r % 2 == 0) ? 32'd1 : 32'd2);
            chk("rr_s_adr", s_adr, (r % 2 == 0) ? 32'h0000_1000 : 32'h0000_2000);
            nx();
            s_ack = 1'b0;
            if (r % 2 == 0) begin m0_cyc = 1'b0; m0_stb = 1'b0; end
            else begin m1_cyc = 1'b0; m1_stb = 1'b0; end
            nx();
            if (r % 2 == 0) begin m0_cyc = 1'b1; m0_stb = 1'b1; end
            else begin m1_cyc = 1'b1; m1_stb = 1'b1; end
            smp();
            chk("rr_idle_gap", 32'(grant), 32'd0);
        end

        // Lock: m0 keeps the bus for 4 beats while m1 waits
        do_reset();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_adr = 32'h100;
        nx();
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h200;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) nx();
            m0_adr = 32'h100 + 32'(4 * i);
            s_ack = 1'b1;
            smp();
            chk("lock_adr", s_adr, 32'h100 + 32'(4 * i));
            chk("lock_grant", 32'(grant), 32'd1);
            chk("lock_m1_ack", 32'(m1_ack), 32'd0);
            chk("lock_m0_ack", 32'(m0_ack), 32'd1);
        end
        nx();
        s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
        smp();
        chk("lock_release", 32'(grant), 32'd1);
        nx(); smp();
        chk("lock_gap", 32'(grant), 32'd0);
        nx(); smp();
        chk("lock_m1_grant", 32'(grant), 32'd2);
        chk("lock_m1_adr", s_adr, 32'h200);

        // Watchdog: m1 write never acknowledged
        do_reset();
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_adr = 32'h300; m1_dat_w = 32'h1234_5678;
        nx();
        for (int k = 0; k < 16; k++) begin
            if (k > 0) nx();
            smp();
            if (k < 15) begin
                chk("wd_no_err", 32'(m1_err), 32'd0);
                chk("wd_stb_fwd", 32'(s_stb), 32'd1);
            end else begin
                chk("wd_err", 32'(m1_err), 32'd1);
                chk("wd_stb_off", 32'(s_stb), 32'd0);
                chk("wd_m0_err", 32'(m0_err), 32'd0);
            end
        end
        nx(); smp();
        chk("wd_err_pulse", 32'(m1_err), 32'd0);
        chk("wd_idle", 32'(grant), 32'd0);
        chk("wd_tcnt1", 32'(timeout_cnt), 32'd1);

        // Ack in the expiry cycle wins
        nx(); smp();
        chk("edge_regrant", 32'(grant), 32'd2);
        for (int k = 1; k < 16; k++) begin
            nx();
            if (k == 15) s_ack = 1'b1;
            smp();
        end
        chk("edge_ack", 32'(m1_ack), 32'd1);
        chk("edge_no_err", 32'(m1_err), 32'd0);
        nx();
        drop_all();
        nx(); smp();
        chk("edge_tcnt", 32'(timeout_cnt), 32'd1);

        // Saturation after five expiries in total
        m1_cyc = 1'b1; m1_stb = 1'b1;
        exp_tc = 2'd1;
        for (int n = 0; n < 4; n++) begin
            wait_err(seen);
            chk("sat_err_seen", 32'(seen), 32'd1);
            if (exp_tc != 2'd3) exp_tc = exp_tc + 2'd1;
            nx(); smp();
            chk("sat_tcnt", 32'(timeout_cnt), 32'(exp_tc));
        end
        drop_all();

        // Reset while m1 owns the bus with a pending strobe
        do_reset();
        m1_cyc = 1'b1; m1_stb = 1'b1;
        nx(); smp();
        chk("mrst_owner", 32'(grant), 32'd2);
        nx();
        reset = 1'b1; m0_cyc = 1'b1; m0_stb = 1'b1;
        nx();
        reset = 1'b0;
        smp();
        chk("mrst_grant", 32'(grant), 32'd0);
        chk("mrst_s_cyc", 32'(s_cyc), 32'd0);
        chk("mrst_resp", 32'({m0_ack, m1_ack, m0_err, m1_err}), 32'd0);
        nx(); smp();
        chk("mrst_m0_first", 32'(grant), 32'd1);
        drop_all();
        nx();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_time_limit got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/wb_ddr_arbiter.md
Name: wb_ddr_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter that shares the DDR controller slave port between the LM32 instruction bus (master 0) and data bus (master 1).
- Round-robin grant with bus lock for the duration of a master's cyc.
- Watchdog terminates transfers the slave never acknowledges with an error, so a stalled DDR init or a controller fault cannot hang the CPU.
- Sits in system between the lm32 bus ports and the DDR controller's Wishbone port.

Parameters:
- timeout, 1024, cycles a granted stb may wait without ack before the watchdog fires (range 2..65535)
- tcnt_width, 8, width of the saturating timeout event counter

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_cyc, m0_stb, m0_we  in  1 each  master 0 (instruction bus) cycle, strobe, write enable
- m0_sel  in  4  master 0 byte selects
- m0_adr  in  32  master 0 address
- m0_dat_w  in  32  master 0 write data
- m0_dat_r  out  32  master 0 read data
- m0_ack, m0_err  out  1 each  master 0 acknowledge, error
- m1_*  same set and widths as m0_*  master 1 (data bus)
- s_cyc, s_stb, s_we  out  1 each  slave cycle, strobe, write enable
- s_sel  out  4  slave byte selects
- s_adr  out  32  slave address
- s_dat_w  out  32  slave write data
- s_dat_r  in  32  slave read data
- s_ack  in  1  slave acknowledge
- grant  out  2  one-hot current owner; 00 = idle
- timeout_cnt  out  tcnt_width  saturating count of watchdog events

Behaviour:
- Reset values: state IDLE, grant=00, last=1 (so master 0 wins the first tie), s_cyc=s_stb=0, m*_ack=m*_err=0, watchdog counter=0, timeout_cnt=0. Reset mid-transfer aborts immediately; no ack or err is issued.
- FSM states: IDLE, BUS0, BUS1.
- IDLE:
  - Only m0_cyc -> BUS0; only m1_cyc -> BUS1.
  - Both -> the master not equal to `last`.
  - None -> stay in IDLE.
  - Arbitration latency is 1 cycle: a request seen in IDLE is granted on the next edge.
- BUSx:
  - grant[x]=1; s_cyc=mx_cyc; s_stb=mx_stb.
  - s_we, s_sel, s_adr, s_dat_w mux combinationally from master x.
  - mx_ack=s_ack & mx_stb. The other master's ack and err are 0.
  - Stay while mx_cyc=1 (lock covers multi-beat and RMW sequences).
  - When mx_cyc=0 -> IDLE, and last<=x. At least one idle cycle always separates two grants.
- Outside BUSx, s_cyc and s_stb are 0. When not granted, a master's stb is ignored and never forwarded.
- m0_dat_r and m1_dat_r both carry s_dat_r unconditionally; validity is qualified by ack.
- Watchdog:
  - Counter increments each cycle the state is BUSx with s_stb=1 and s_ack=0.
  - Clears on s_ack, on leaving BUSx, or when s_stb=0.
  - On reaching timeout-1 with no ack that cycle: mx_err=1 for exactly one cycle, s_stb forced 0 that cycle, timeout_cnt increments (saturating at all-ones), state -> IDLE, last<=x.
  - If the master keeps cyc high it is re-arbitrated from IDLE like any requester.
- s_ack arriving in the same cycle as expiry: the ack wins; no err is issued and the count is not incremented.
- s_ack while IDLE (spurious) is ignored; no master sees it.

Decomposition:
- Shared package/header (system_defines): state encodings (IDLE=0, BUS0=1, BUS1=2), the Wishbone sel width (4), and the data/address width (32).
- One sub-module: wb_watchdog, holding the counter, compare, err pulse and saturating event counter, with parameters timeout and tcnt_width.
- Arbiter FSM and muxes stay in wb_ddr_arbiter.

Test Plan:
- Single master: m1 reads adr 0x40000010; slave acks after 3 cycles with s_dat_r=0xDEADBEEF -> grant=10 one cycle after m1_cyc; m1_ack for one cycle with m1_dat_r=0xDEADBEEF; m0_ack stays 0.
- Simultaneous request after reset: m0 and m1 assert cyc in the same cycle -> m0 granted first. After m0 drops cyc: one IDLE cycle, then grant=10. Repeat -> grants alternate m0, m1, m0 ...
- Lock: m0 holds cyc over 4 stb beats while m1 requests -> all 4 beats go to the slave with s_adr from m0; grant=01 throughout; m1 is granted only after m0_cyc falls.
- Timeout: timeout=16, slave never acks a m1 write -> m1_err pulses exactly 16 cycles after the stb reached the slave; timeout_cnt becomes 1; state returns to IDLE; s_stb=0 in the err cycle.
- Edge case: s_ack in the expiry cycle -> m*_ack=1, no err, timeout_cnt unchanged. Saturation: with tcnt_width=2, 5 timeouts -> timeout_cnt=3.
- Reset mid-transfer: reset asserted while in BUS1 with stb pending -> next cycle grant=00, s_cyc=0, no ack or err; m0 is granted first afterwards.
